// File: rtl/issue_ctrl_pkg.sv
// Shared encodings for the issue stage: destination zones (mirroring riscv_defs.v) and FSM states.
package issue_ctrl_pkg;

  localparam logic [1:0] ZONE_NONE    = 2'd0;
  localparam logic [1:0] ZONE_REGFILE = 2'd1;
  localparam logic [1:0] ZONE_LOADQ   = 2'd2;
  localparam logic [1:0] ZONE_STOREQ  = 2'd3;

  typedef enum logic {
    ISSUE_ST_ISSUE = 1'b0,
    ISSUE_ST_DRAIN = 1'b1
  } issue_st_e;

  // A register operand only blocks when it is actually read and is not x0.
  function automatic logic operand_blocked(input logic used, input logic [4:0] addr,
                                           input logic pend);
    return used && (addr != 5'd0) && pend;
  endfunction

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// 32-entry pending-writeback scoreboard: one set port, one clear port, three read ports.
module issue_ctrl_scoreboard (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       set_en_i,
  input  logic [4:0] set_addr_i,
  input  logic       clr_en_i,
  input  logic [4:0] clr_addr_i,
  input  logic [4:0] rs1_addr_i,
  input  logic [4:0] rs2_addr_i,
  input  logic [4:0] rd_addr_i,
  output logic       rs1_pend_o,
  output logic       rs2_pend_o,
  output logic       rd_pend_o
);

  logic [31:0] sb_q, sb_d;

  always_comb begin
    sb_d = sb_q;
    if (clr_en_i) sb_d[clr_addr_i] = 1'b0;
    // A newly issued load is younger than any retiring one, so its set wins.
    if (set_en_i) sb_d[set_addr_i] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) sb_q <= '0;
    else         sb_q <= sb_d;
  end

  assign rs1_pend_o = sb_q[rs1_addr_i];
  assign rs2_pend_o = sb_q[rs2_addr_i];
  assign rd_pend_o  = sb_q[rd_addr_i];

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue scheduler: hazard/occupancy stalls, serialising drain and the execute output register.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int unsigned C_ZONE_SZ    = 2,
  parameter int unsigned C_LQ_DEPTH   = 4,
  parameter int unsigned C_SQ_DEPTH   = 4,
  parameter int unsigned C_PAYLOAD_SZ = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    ids_valid_i,
  output logic                    ids_ready_o,
  input  logic [C_ZONE_SZ-1:0]    ids_zone_i,
  input  logic [4:0]              ids_regd_addr_i,
  input  logic [4:0]              ids_regs1_addr_i,
  input  logic [4:0]              ids_regs2_addr_i,
  input  logic                    ids_rs1_used_i,
  input  logic                    ids_rs2_used_i,
  input  logic                    ids_csr_access_i,
  input  logic                    ids_ins_err_i,
  input  logic [C_PAYLOAD_SZ-1:0] ids_payload_i,
  output logic                    ex_valid_o,
  input  logic                    ex_ready_i,
  input  logic                    ex_flush_i,
  output logic [C_ZONE_SZ-1:0]    ex_zone_o,
  output logic [4:0]              ex_regd_addr_o,
  output logic                    ex_ins_err_o,
  output logic [C_PAYLOAD_SZ-1:0] ex_payload_o,
  input  logic                    lq_wb_valid_i,
  input  logic [4:0]              lq_wb_addr_i,
  input  logic                    sq_retire_i
);

  localparam int unsigned LqW = $clog2(C_LQ_DEPTH + 1);
  localparam int unsigned SqW = $clog2(C_SQ_DEPTH + 1);

  issue_st_e state_q, state_d;

  logic                    ex_valid_q;
  logic [C_ZONE_SZ-1:0]    ex_zone_q;
  logic [4:0]              ex_regd_q;
  logic                    ex_err_q;
  logic [C_PAYLOAD_SZ-1:0] ex_payload_q;
  logic [LqW-1:0]          lq_cnt_q, lq_cnt_d;
  logic [SqW-1:0]          sq_cnt_q, sq_cnt_d;

  logic in_rf, in_lq, in_sq, ex_is_lq, ex_is_sq, ex_pend_lq;
  logic sb_rs1, sb_rs2, sb_rd, pend_rs1, pend_rs2, pend_rd;
  logic hazard, full, serialising, busy, issue_hs, accept, lq_inc, sq_inc;

  assign in_rf    = ids_zone_i == C_ZONE_SZ'(ZONE_REGFILE);
  assign in_lq    = ids_zone_i == C_ZONE_SZ'(ZONE_LOADQ);
  assign in_sq    = ids_zone_i == C_ZONE_SZ'(ZONE_STOREQ);
  assign ex_is_lq = ex_zone_q == C_ZONE_SZ'(ZONE_LOADQ);
  assign ex_is_sq = ex_zone_q == C_ZONE_SZ'(ZONE_STOREQ);

  assign ex_pend_lq = ex_valid_q && ex_is_lq;
  assign issue_hs   = ex_valid_q && ex_ready_i && !ex_flush_i;
  assign accept     = ids_valid_i && ids_ready_o && !ex_flush_i;
  assign lq_inc     = issue_hs && ex_is_lq;
  assign sq_inc     = issue_hs && ex_is_sq;

  issue_ctrl_scoreboard u_scoreboard (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .set_en_i   (lq_inc && (ex_regd_q != 5'd0)),
    .set_addr_i (ex_regd_q),
    .clr_en_i   (lq_wb_valid_i),
    .clr_addr_i (lq_wb_addr_i),
    .rs1_addr_i (ids_regs1_addr_i),
    .rs2_addr_i (ids_regs2_addr_i),
    .rd_addr_i  (ids_regd_addr_i),
    .rs1_pend_o (sb_rs1),
    .rs2_pend_o (sb_rs2),
    .rd_pend_o  (sb_rd)
  );

  // A load sitting in the output register is not yet in the scoreboard but is just as pending.
  assign pend_rs1 = sb_rs1 || (ex_pend_lq && (ex_regd_q == ids_regs1_addr_i));
  assign pend_rs2 = sb_rs2 || (ex_pend_lq && (ex_regd_q == ids_regs2_addr_i));
  assign pend_rd  = sb_rd  || (ex_pend_lq && (ex_regd_q == ids_regd_addr_i));

  assign hazard = operand_blocked(ids_rs1_used_i, ids_regs1_addr_i, pend_rs1) ||
                  operand_blocked(ids_rs2_used_i, ids_regs2_addr_i, pend_rs2) ||
                  operand_blocked(in_rf || in_lq, ids_regd_addr_i, pend_rd);

  assign full = (in_lq && ((32'(lq_cnt_q) + 32'(ex_pend_lq)) >= C_LQ_DEPTH)) ||
                (in_sq && ((32'(sq_cnt_q) + 32'(ex_valid_q && ex_is_sq)) >= C_SQ_DEPTH));

  assign serialising = ids_csr_access_i || ids_ins_err_i;
  assign busy        = (lq_cnt_q != '0) || (sq_cnt_q != '0) || ex_valid_q;

  always_comb begin
    lq_cnt_d = lq_cnt_q;
    if (lq_inc && !lq_wb_valid_i && (32'(lq_cnt_q) < C_LQ_DEPTH)) begin
      lq_cnt_d = lq_cnt_q + LqW'(1);
    end else if (!lq_inc && lq_wb_valid_i && (lq_cnt_q != '0)) begin
      lq_cnt_d = lq_cnt_q - LqW'(1);
    end
    sq_cnt_d = sq_cnt_q;
    if (sq_inc && !sq_retire_i && (32'(sq_cnt_q) < C_SQ_DEPTH)) begin
      sq_cnt_d = sq_cnt_q + SqW'(1);
    end else if (!sq_inc && sq_retire_i && (sq_cnt_q != '0)) begin
      sq_cnt_d = sq_cnt_q - SqW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ISSUE_ST_ISSUE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ex_flush_i) begin
      state_d = ISSUE_ST_ISSUE;
    end else begin
      unique case (state_q)
        ISSUE_ST_ISSUE: if (ids_valid_i && serialising && busy) state_d = ISSUE_ST_DRAIN;
        ISSUE_ST_DRAIN: if (!busy) state_d = ISSUE_ST_ISSUE;
        default:        state_d = ISSUE_ST_ISSUE;
      endcase
    end
  end

  // A flush swallows whatever decode offers that cycle, hence ready is forced high.
  always_comb begin
    ids_ready_o = 1'b0;
    if (reset_i) begin
      ids_ready_o = 1'b0;
    end else if (ex_flush_i) begin
      ids_ready_o = 1'b1;
    end else if (state_q == ISSUE_ST_ISSUE) begin
      ids_ready_o = (!ex_valid_q || ex_ready_i) && !hazard && !full && !(serialising && busy);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ex_valid_q   <= 1'b0;
      ex_zone_q    <= '0;
      ex_regd_q    <= '0;
      ex_err_q     <= 1'b0;
      ex_payload_q <= '0;
      lq_cnt_q     <= '0;
      sq_cnt_q     <= '0;
    end else begin
      lq_cnt_q <= lq_cnt_d;
      sq_cnt_q <= sq_cnt_d;
      if (ex_flush_i)    ex_valid_q <= 1'b0;
      else if (accept)   ex_valid_q <= 1'b1;
      else if (issue_hs) ex_valid_q <= 1'b0;
      if (accept) begin
        ex_zone_q    <= ids_zone_i;
        ex_regd_q    <= ids_regd_addr_i;
        ex_err_q     <= ids_ins_err_i;
        ex_payload_q <= ids_payload_i;
      end
    end
  end

  assign ex_valid_o     = ex_valid_q;
  assign ex_zone_o      = ex_zone_q;
  assign ex_regd_addr_o = ex_regd_q;
  assign ex_ins_err_o   = ex_err_q;
  assign ex_payload_o   = ex_payload_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: vector table, directed corner sequences, random vs. model.
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  localparam int unsigned LqDepth = 4;
  localparam int unsigned SqDepth = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ids_valid = 1'b0, ids_ready;
  logic [1:0]  ids_zone = '0;
  logic [4:0]  ids_rd = '0, ids_rs1 = '0, ids_rs2 = '0;
  logic        ids_u1 = 1'b0, ids_u2 = 1'b0, ids_csr = 1'b0, ids_err = 1'b0;
  logic [63:0] ids_pl = '0;
  logic        ex_valid, ex_ready = 1'b0, ex_flush = 1'b0;
  logic [1:0]  ex_zone;
  logic [4:0]  ex_rd;
  logic        ex_err;
  logic [63:0] ex_pl;
  logic        lq_wb = 1'b0, sq_ret = 1'b0;
  logic [4:0]  lq_wb_addr = '0;

  int n_chk = 0;
  int n_fail = 0;

  issue_ctrl #(
    .C_ZONE_SZ    (2),
    .C_LQ_DEPTH   (LqDepth),
    .C_SQ_DEPTH   (SqDepth),
    .C_PAYLOAD_SZ (64)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .ids_valid_i      (ids_valid),
    .ids_ready_o      (ids_ready),
    .ids_zone_i       (ids_zone),
    .ids_regd_addr_i  (ids_rd),
    .ids_regs1_addr_i (ids_rs1),
    .ids_regs2_addr_i (ids_rs2),
    .ids_rs1_used_i   (ids_u1),
    .ids_rs2_used_i   (ids_u2),
    .ids_csr_access_i (ids_csr),
    .ids_ins_err_i    (ids_err),
    .ids_payload_i    (ids_pl),
    .ex_valid_o       (ex_valid),
    .ex_ready_i       (ex_ready),
    .ex_flush_i       (ex_flush),
    .ex_zone_o        (ex_zone),
    .ex_regd_addr_o   (ex_rd),
    .ex_ins_err_o     (ex_err),
    .ex_payload_o     (ex_pl),
    .lq_wb_valid_i    (lq_wb),
    .lq_wb_addr_i     (lq_wb_addr),
    .sq_retire_i      (sq_ret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic vld; logic [1:0] zone; logic [4:0] rd, rs1, rs2; logic u1, u2, exr, wb;
    logic [4:0] wba; logic sqr; logic [63:0] pl; logic rdy, exv; logic [63:0] epl;
  } vec_t;

  function automatic vec_t mk(input logic vld, input logic [1:0] zone, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                              input logic u2, input logic exr, input logic wb,
                              input logic [4:0] wba, input logic sqr, input logic [63:0] pl,
                              input logic rdy, input logic exv, input logic [63:0] epl);
    vec_t v;
    v.vld = vld; v.zone = zone; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.exr = exr; v.wb = wb; v.wba = wba; v.sqr = sqr; v.pl = pl; v.rdy = rdy; v.exv = exv;
    v.epl = epl;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    ids_valid = 0; ids_zone = ZONE_NONE; ids_rd = 0; ids_rs1 = 0; ids_rs2 = 0;
    ids_u1 = 0; ids_u2 = 0; ids_csr = 0; ids_err = 0; ids_pl = 0;
    ex_flush = 0; lq_wb = 0; lq_wb_addr = 0; sq_ret = 0;
  endtask

  task automatic set_ins(input logic [1:0] z, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic csr, input logic [63:0] pl);
    ids_valid = 1; ids_zone = z; ids_rd = rd; ids_rs1 = rs1; ids_rs2 = rs2;
    ids_u1 = u1; ids_u2 = u2; ids_csr = csr; ids_err = 0; ids_pl = pl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    ex_ready = 0;
    reset = 1;
    tick();
    check("reset_ready", ids_ready, 0);
    check("reset_ex_fields", {ex_valid, ex_zone, ex_rd, ex_err}, 0);
    check("reset_ex_payload", ex_pl, 0);
    reset = 0;
    tick();
  endtask

  // Reference model state: behaviour derived from the issue rules, not the RTL structure.
  bit          m_exv;
  logic [1:0]  m_ex_zone;
  logic [4:0]  m_ex_rd;
  logic        m_ex_err;
  logic [63:0] m_ex_pl;
  int          m_lq, m_sq;
  bit          m_sb[32];
  logic [4:0]  m_ldq[$];
  bit          m_drain;

  function automatic bit m_pend(input logic [4:0] r);
    return m_sb[r] || (m_exv && m_ex_zone == ZONE_LOADQ && m_ex_rd == r);
  endfunction

  function automatic bit m_busy();
    return (m_lq > 0) || (m_sq > 0) || m_exv;
  endfunction

  function automatic bit m_ready();
    bit haz, full;
    int occ_lq, occ_sq;
    if (ex_flush) return 1;
    if (m_drain) return 0;
    haz = (ids_u1 && ids_rs1 != 0 && m_pend(ids_rs1)) ||
          (ids_u2 && ids_rs2 != 0 && m_pend(ids_rs2)) ||
          ((ids_zone == ZONE_REGFILE || ids_zone == ZONE_LOADQ) && ids_rd != 0 && m_pend(ids_rd));
    occ_lq = m_lq + ((m_exv && m_ex_zone == ZONE_LOADQ) ? 1 : 0);
    occ_sq = m_sq + ((m_exv && m_ex_zone == ZONE_STOREQ) ? 1 : 0);
    full = (ids_zone == ZONE_LOADQ && occ_lq >= int'(LqDepth)) ||
           (ids_zone == ZONE_STOREQ && occ_sq >= int'(SqDepth));
    return (!m_exv || ex_ready) && !haz && !full && !((ids_csr || ids_err) && m_busy());
  endfunction

  localparam int NV = 12;
  vec_t vecs[NV];

  initial begin
    vec_t v;
    bit exp_rdy, acc, iss, busy;

    vecs[0]  = mk(1, ZONE_REGFILE, 1, 2, 3, 1, 1, 1, 0, 0, 0, 100, 1, 1, 100);
    vecs[1]  = mk(1, ZONE_REGFILE, 2, 3, 4, 1, 1, 1, 0, 0, 0, 101, 1, 1, 101);
    vecs[2]  = mk(1, ZONE_REGFILE, 3, 1, 2, 1, 1, 1, 0, 0, 0, 102, 1, 1, 102);
    vecs[3]  = mk(1, ZONE_LOADQ,   5, 1, 0, 1, 0, 1, 0, 0, 0, 103, 1, 1, 103);
    vecs[4]  = mk(1, ZONE_REGFILE, 6, 5, 1, 1, 1, 1, 0, 0, 0, 104, 0, 0, 0);
    vecs[5]  = mk(1, ZONE_REGFILE, 6, 5, 1, 1, 1, 1, 0, 0, 0, 104, 0, 0, 0);
    vecs[6]  = mk(1, ZONE_REGFILE, 6, 5, 1, 1, 1, 1, 1, 5, 0, 104, 0, 0, 0);
    vecs[7]  = mk(1, ZONE_REGFILE, 6, 5, 1, 1, 1, 1, 0, 0, 0, 104, 1, 1, 104);
    vecs[8]  = mk(1, ZONE_STOREQ,  0, 6, 7, 1, 1, 1, 0, 0, 0, 105, 1, 1, 105);
    vecs[9]  = mk(1, ZONE_REGFILE, 7, 1, 1, 1, 1, 0, 0, 0, 0, 106, 0, 1, 105);
    vecs[10] = mk(1, ZONE_REGFILE, 7, 1, 1, 1, 1, 1, 0, 0, 0, 106, 1, 1, 106);
    vecs[11] = mk(0, ZONE_NONE,    0, 0, 0, 0, 0, 1, 0, 0, 1, 0,   1, 0, 0);

    do_reset();

    // ADD stream, load-use stall, store and output-register backpressure.
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      idle_in();
      ids_valid = v.vld; ids_zone = v.zone; ids_rd = v.rd; ids_rs1 = v.rs1; ids_rs2 = v.rs2;
      ids_u1 = v.u1; ids_u2 = v.u2; ids_pl = v.pl; ex_ready = v.exr;
      lq_wb = v.wb; lq_wb_addr = v.wba; sq_ret = v.sqr;
      #1;
      check($sformatf("vec%0d_ready", i), ids_ready, v.rdy);
      tick();
      check($sformatf("vec%0d_ex_valid", i), ex_valid, v.exv);
      if (v.exv) check($sformatf("vec%0d_ex_payload", i), ex_pl, v.epl);
    end

    // Load queue full: fifth load waits for one writeback.
    do_reset();
    ex_ready = 1;
    for (int k = 0; k < 4; k++) begin
      set_ins(ZONE_LOADQ, 5'(10 + k), 0, 0, 0, 0, 0, 64'(200 + k));
      #1;
      check($sformatf("lq_fill%0d_ready", k), ids_ready, 1);
      tick();
    end
    set_ins(ZONE_LOADQ, 14, 0, 0, 0, 0, 0, 204);
    #1;
    check("lq_full_stall", ids_ready, 0);
    tick();
    check("lq_full_stall2", ids_ready, 0);
    lq_wb = 1; lq_wb_addr = 10;
    #1;
    check("lq_wb_same_cycle", ids_ready, 0);
    tick();
    lq_wb = 0;
    #1;
    check("lq_free_accept", ids_ready, 1);
    tick();
    check("lq_fifth_ex_valid", ex_valid, 1);
    check("lq_fifth_payload", ex_pl, 204);

    // CSR drains behind two outstanding stores.
    do_reset();
    ex_ready = 1;
    set_ins(ZONE_STOREQ, 0, 1, 2, 1, 1, 0, 300);
    tick();
    set_ins(ZONE_STOREQ, 0, 1, 2, 1, 1, 0, 301);
    tick();
    idle_in();
    tick();
    set_ins(ZONE_REGFILE, 8, 1, 0, 1, 0, 1, 302);
    #1;
    check("csr_busy_stall", ids_ready, 0);
    tick();
    sq_ret = 1;
    #1;
    check("csr_drain0", ids_ready, 0);
    tick();
    check("csr_drain1", ids_ready, 0);
    tick();
    sq_ret = 0;
    #1;
    check("csr_drain_exit", ids_ready, 0);
    tick();
    check("csr_issue_ready", ids_ready, 1);
    tick();
    check("csr_ex_valid", ex_valid, 1);
    check("csr_ex_payload", ex_pl, 302);

    // Flush with a load in the output register.
    do_reset();
    ex_ready = 0;
    set_ins(ZONE_LOADQ, 9, 0, 0, 0, 0, 0, 400);
    tick();
    ex_flush = 1;
    set_ins(ZONE_REGFILE, 20, 9, 0, 1, 0, 0, 401);
    #1;
    check("flush_ready", ids_ready, 1);
    tick();
    ex_flush = 0;
    check("flush_kill", ex_valid, 0);
    ex_ready = 1;
    set_ins(ZONE_REGFILE, 21, 0, 0, 0, 0, 1, 402);
    #1;
    check("flush_no_count", ids_ready, 1);
    tick();
    check("flush_csr_payload", ex_pl, 402);
    set_ins(ZONE_REGFILE, 22, 9, 0, 1, 0, 0, 403);
    #1;
    check("flush_no_sb", ids_ready, 1);
    tick();

    // Reset asserted asynchronously while draining with three loads outstanding.
    do_reset();
    ex_ready = 1;
    for (int k = 0; k < 4; k++) begin
      set_ins(ZONE_LOADQ, 5'(11 + k), 0, 0, 0, 0, 0, 64'(500 + k));
      tick();
    end
    ex_ready = 0;
    set_ins(ZONE_REGFILE, 8, 0, 0, 0, 0, 1, 510);
    tick();
    check("pre_rst_ex_valid", ex_valid, 1);
    #2;
    reset = 1;
    #1;
    check("rst_async_ready", ids_ready, 0);
    check("rst_async_ex", {ex_valid, ex_zone, ex_rd, ex_err}, 0);
    check("rst_async_payload", ex_pl, 0);
    tick();
    reset = 0;
    ex_ready = 1;
    set_ins(ZONE_REGFILE, 8, 11, 0, 1, 0, 1, 511);
    #1;
    check("rst_issue_state", ids_ready, 1);
    tick();

    // Randomised traffic against the reference model.
    do_reset();
    m_exv = 0; m_ex_zone = 0; m_ex_rd = 0; m_ex_err = 0; m_ex_pl = 0;
    m_lq = 0; m_sq = 0; m_drain = 0; m_ldq.delete();
    for (int r = 0; r < 32; r++) m_sb[r] = 0;
    for (int c = 0; c < 3000; c++) begin
      idle_in();
      ids_valid = ($urandom % 4) != 0;
      ids_zone  = 2'($urandom % 4);
      ids_rd    = 5'($urandom % 8);
      ids_rs1   = 5'($urandom % 8);
      ids_rs2   = 5'($urandom % 8);
      ids_u1    = 1'($urandom % 2);
      ids_u2    = 1'($urandom % 2);
      ids_csr   = ($urandom % 16) == 0;
      ids_err   = ($urandom % 20) == 0;
      ids_pl    = {$urandom, $urandom};
      ex_ready  = ($urandom % 10) < 7;
      ex_flush  = ($urandom % 25) == 0;
      if (m_ldq.size() > 0 && ($urandom % 3) == 0) begin
        lq_wb = 1; lq_wb_addr = m_ldq[0];
      end
      sq_ret = (m_sq > 0) && (($urandom % 3) == 0);
      #1;
      exp_rdy = m_ready();
      check($sformatf("rnd%0d_ready", c), ids_ready, exp_rdy);

      busy = m_busy();
      acc  = ids_valid && exp_rdy && !ex_flush;
      iss  = m_exv && ex_ready && !ex_flush;
      if (lq_wb) begin
        m_lq--; m_sb[lq_wb_addr] = 0; void'(m_ldq.pop_front());
      end
      if (sq_ret) m_sq--;
      if (iss && m_ex_zone == ZONE_LOADQ) begin
        m_lq++; m_ldq.push_back(m_ex_rd);
        if (m_ex_rd != 0) m_sb[m_ex_rd] = 1;
      end
      if (iss && m_ex_zone == ZONE_STOREQ) m_sq++;
      if (ex_flush) m_drain = 0;
      else if (!m_drain && ids_valid && (ids_csr || ids_err) && busy) m_drain = 1;
      else if (m_drain && !busy) m_drain = 0;
      if (acc) begin
        m_ex_zone = ids_zone; m_ex_rd = ids_rd; m_ex_err = ids_err; m_ex_pl = ids_pl;
      end
      m_exv = ex_flush ? 0 : (acc ? 1 : (iss ? 0 : m_exv));

      tick();
      check($sformatf("rnd%0d_ex_valid", c), ex_valid, m_exv);
      if (m_exv) begin
        check($sformatf("rnd%0d_ex_fields", c), {ex_zone, ex_rd, ex_err},
              {m_ex_zone, m_ex_rd, m_ex_err});
        check($sformatf("rnd%0d_ex_payload", c), ex_pl, m_ex_pl);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1);
  end

endmodule
